// File: rtl/ex_stage_pkg.sv
// Shared CPU encodings for the execute stage: forward selects, ALU ops and
// result selects, plus the operand-forwarding mux used by EX.
package ex_stage_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10,
    FWD_RSV = 2'b11
  } fwd_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } aluc_e;

  typedef enum logic [1:0] {
    ANS_ALU   = 2'b00,
    ANS_SHIFT = 2'b01,
    ANS_LINK  = 2'b10,
    ANS_SLT   = 2'b11
  } ans_sel_e;

  localparam int unsigned XLEN = 32;

  // Operand forwarding: the reserved encoding falls back to the register file value
  function automatic logic [XLEN-1:0] fwd_mux(input fwd_e             sel,
                                              input logic [XLEN-1:0] rf_val,
                                              input logic [XLEN-1:0] mem_val,
                                              input logic [XLEN-1:0] wb_val);
    logic [XLEN-1:0] r;
    r = rf_val;
    case (sel)
      FWD_MEM: r = mem_val;
      FWD_WB:  r = wb_val;
      default: r = rf_val;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_stage_dffe.sv
// Enabled D flip-flop with synchronous clear; clear has priority over enable.
module dffe_sc #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Clear wins, otherwise load when enabled, otherwise hold
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/ex_stage_shifter32.sv
// 32-bit combinational barrel shifter: logical left, logical right, arithmetic right.
module shifter32 (
  input  logic [31:0] b_i,
  input  logic [4:0]  sa_i,
  input  logic        right_i,
  input  logic        arith_i,
  output logic [31:0] y_o
);

  // Select shift direction/kind; a zero amount passes the input unchanged
  always_comb begin
    y_o = b_i;
    if (!right_i) begin
      y_o = b_i << sa_i;
    end else if (arith_i) begin
      y_o = $unsigned($signed(b_i) >>> sa_i);
    end else begin
      y_o = b_i >> sa_i;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, shifter, result select and the
// EX/MEM pipeline register with bubble insertion on flush.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        En,
  input  logic        Flush,
  input  logic        eWreg,
  input  logic        eReg2reg,
  input  logic        eWmem,
  input  logic [5:0]  eOp,
  input  logic [1:0]  eAluc,
  input  logic        eAluqb,
  input  logic [31:0] ePc,
  input  logic [31:0] eR1,
  input  logic [31:0] eR2,
  input  logic [31:0] eI,
  input  logic [4:0]  eRd,
  input  logic [1:0]  eFwdA,
  input  logic [1:0]  eFwdB,
  input  logic [4:0]  eSa,
  input  logic        esArith,
  input  logic        esRight,
  input  logic [1:0]  eAnsSel,
  input  logic [31:0] wD,
  output logic        Z,
  output logic        mWreg,
  output logic        mReg2reg,
  output logic        mWmem,
  output logic [5:0]  mOp,
  output logic [4:0]  mRd,
  output logic [31:0] mAns,
  output logic [31:0] mB
);

  logic [31:0] op_a;
  logic [31:0] fwd_b;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic [31:0] sh_y;
  logic [31:0] ans_d;
  logic        ctrl_clr;

  // Operand selection; mAns here is the register output, so no loop through ans_d
  always_comb begin
    op_a  = fwd_mux(fwd_e'(eFwdA), eR1, mAns, wD);
    fwd_b = fwd_mux(fwd_e'(eFwdB), eR2, mAns, wD);
    alu_b = eAluqb ? fwd_b : eI;
  end

  // ALU and zero flag for branch resolution
  always_comb begin
    alu_y = '0;
    case (aluc_e'(eAluc))
      ALU_ADD: alu_y = op_a + alu_b;
      ALU_SUB: alu_y = op_a - alu_b;
      ALU_AND: alu_y = op_a & alu_b;
      ALU_OR:  alu_y = op_a | alu_b;
      default: alu_y = '0;
    endcase
    Z = (alu_y == '0);
  end

  shifter32 u_shifter (
    .b_i     (fwd_b),
    .sa_i    (eSa),
    .right_i (esRight),
    .arith_i (esArith),
    .y_o     (sh_y)
  );

  // Result select
  always_comb begin
    ans_d = alu_y;
    case (ans_sel_e'(eAnsSel))
      ANS_ALU:   ans_d = alu_y;
      ANS_SHIFT: ans_d = sh_y;
      ANS_LINK:  ans_d = ePc;
      ANS_SLT:   ans_d = {31'b0, ($signed(op_a) < $signed(alu_b))};
      default:   ans_d = alu_y;
    endcase
  end

  // Control fields are zeroed on reset or on an enabled flush (bubble); data fields only on reset
  assign ctrl_clr = Rst | (En & Flush);

  dffe_sc #(.WIDTH(1)) u_wreg (
    .clk_i(Clk), .clr_i(ctrl_clr), .en_i(En), .d_i(eWreg), .q_o(mWreg)
  );
  dffe_sc #(.WIDTH(1)) u_reg2reg (
    .clk_i(Clk), .clr_i(ctrl_clr), .en_i(En), .d_i(eReg2reg), .q_o(mReg2reg)
  );
  dffe_sc #(.WIDTH(1)) u_wmem (
    .clk_i(Clk), .clr_i(ctrl_clr), .en_i(En), .d_i(eWmem), .q_o(mWmem)
  );
  dffe_sc #(.WIDTH(5)) u_rd (
    .clk_i(Clk), .clr_i(ctrl_clr), .en_i(En), .d_i(eRd), .q_o(mRd)
  );
  dffe_sc #(.WIDTH(6)) u_op (
    .clk_i(Clk), .clr_i(Rst), .en_i(En), .d_i(eOp), .q_o(mOp)
  );
  dffe_sc #(.WIDTH(32)) u_ans (
    .clk_i(Clk), .clr_i(Rst), .en_i(En), .d_i(ans_d), .q_o(mAns)
  );
  dffe_sc #(.WIDTH(32)) u_b (
    .clk_i(Clk), .clr_i(Rst), .en_i(En), .d_i(fwd_b), .q_o(mB)
  );

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: behavioural model plus directed literal checks.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        Rst, En, Flush;
  logic        eWreg, eReg2reg, eWmem;
  logic [5:0]  eOp;
  logic [1:0]  eAluc;
  logic        eAluqb;
  logic [31:0] ePc, eR1, eR2, eI;
  logic [4:0]  eRd;
  logic [1:0]  eFwdA, eFwdB;
  logic [4:0]  eSa;
  logic        esArith, esRight;
  logic [1:0]  eAnsSel;
  logic [31:0] wD;
  logic        Z, mWreg, mReg2reg, mWmem;
  logic [5:0]  mOp;
  logic [4:0]  mRd;
  logic [31:0] mAns, mB;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Model state: what the EX/MEM register must hold
  logic        x_wreg = 0, x_reg2reg = 0, x_wmem = 0;
  logic [5:0]  x_op = '0;
  logic [4:0]  x_rd = '0;
  logic [31:0] x_ans = '0, x_b = '0;

  always #5 clk = ~clk;

  ex_stage dut (
    .Clk(clk), .Rst(Rst), .En(En), .Flush(Flush),
    .eWreg(eWreg), .eReg2reg(eReg2reg), .eWmem(eWmem),
    .eOp(eOp), .eAluc(eAluc), .eAluqb(eAluqb),
    .ePc(ePc), .eR1(eR1), .eR2(eR2), .eI(eI),
    .eRd(eRd), .eFwdA(eFwdA), .eFwdB(eFwdB),
    .eSa(eSa), .esArith(esArith), .esRight(esRight), .eAnsSel(eAnsSel),
    .wD(wD), .Z(Z),
    .mWreg(mWreg), .mReg2reg(mReg2reg), .mWmem(mWmem),
    .mOp(mOp), .mRd(mRd), .mAns(mAns), .mB(mB)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- behavioural model ----
  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r);
    if (s == 2'd1) return x_ans;
    if (s == 2'd2) return wD;
    return r;
  endfunction

  function automatic logic [31:0] m_a();
    return pick(eFwdA, eR1);
  endfunction

  function automatic logic [31:0] m_fb();
    return pick(eFwdB, eR2);
  endfunction

  function automatic logic [31:0] m_alu();
    logic [31:0] a, b;
    a = m_a();
    b = eAluqb ? m_fb() : eI;
    if (eAluc == 2'd0) return a + b;
    if (eAluc == 2'd1) return a - b;
    if (eAluc == 2'd2) return a & b;
    return a | b;
  endfunction

  function automatic logic [31:0] m_ans();
    logic [31:0] a, b, v, s;
    a = m_a();
    b = eAluqb ? m_fb() : eI;
    v = m_fb();
    case (eAnsSel)
      2'd0: return m_alu();
      2'd1: begin
        if (!esRight) return v << eSa;
        s = v >> eSa;
        if (esArith && v[31]) s = s | ~(32'hFFFF_FFFF >> eSa);
        return s;
      end
      2'd2: return ePc;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Advance the model at each rising edge from the pre-edge inputs
  always @(posedge clk) begin
    if (Rst) begin
      x_wreg <= 0; x_reg2reg <= 0; x_wmem <= 0;
      x_op <= '0; x_rd <= '0; x_ans <= '0; x_b <= '0;
    end else if (En) begin
      x_wreg    <= Flush ? 1'b0 : eWreg;
      x_reg2reg <= Flush ? 1'b0 : eReg2reg;
      x_wmem    <= Flush ? 1'b0 : eWmem;
      x_rd      <= Flush ? 5'd0 : eRd;
      x_op      <= eOp;
      x_ans     <= m_ans();
      x_b       <= m_fb();
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      check("mWreg", {31'b0, mWreg}, {31'b0, x_wreg});
      check("mReg2reg", {31'b0, mReg2reg}, {31'b0, x_reg2reg});
      check("mWmem", {31'b0, mWmem}, {31'b0, x_wmem});
      check("mOp", {26'b0, mOp}, {26'b0, x_op});
      check("mRd", {27'b0, mRd}, {27'b0, x_rd});
      check("mAns", mAns, x_ans);
      check("mB", mB, x_b);
      check("Z", {31'b0, Z}, {31'b0, (m_alu() == 32'd0)});
    end
  end

  // ---- stimulus ----
  task automatic go();
    @(posedge clk);
    #2;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic idle();
    Rst = 0; En = 1; Flush = 0;
    eWreg = 0; eReg2reg = 0; eWmem = 0; eOp = '0;
    eAluc = 2'd0; eAluqb = 0; ePc = '0; eR1 = '0; eR2 = '0; eI = '0;
    eRd = '0; eFwdA = 2'd0; eFwdB = 2'd0; eSa = '0;
    esArith = 0; esRight = 0; eAnsSel = 2'd0; wD = '0;
  endtask

  task automatic rand_in();
    eWreg = 1'($urandom); eReg2reg = 1'($urandom); eWmem = 1'($urandom);
    eOp = 6'($urandom); eAluc = 2'($urandom); eAluqb = 1'($urandom);
    ePc = $urandom; eR1 = $urandom; eR2 = $urandom; eI = $urandom;
    eRd = 5'($urandom); eFwdA = 2'($urandom); eFwdB = 2'($urandom);
    eSa = 5'($urandom); esArith = 1'($urandom); esRight = 1'($urandom);
    eAnsSel = 2'($urandom); wD = $urandom;
    if ($urandom_range(0, 5) == 0) begin
      eR2 = eR1; eI = eR1; eFwdA = 2'd0; eFwdB = 2'd0;
    end
  endtask

  initial begin
    idle();
    rand_in();
    Rst = 1; En = 1'($urandom); Flush = 1'($urandom);
    go();
    chk_on = 1'b1;
    look();
    check("rst mAns", mAns, 32'h0);
    check("rst mB", mB, 32'h0);
    check("rst ctrl", {29'b0, mWreg, mReg2reg, mWmem}, 32'h0);
    check("rst mOp/mRd", {21'b0, mOp, mRd}, 32'h0);

    // subtract and zero flag
    go(); idle(); eR1 = 5; eR2 = 3; eAluqb = 1; eAluc = 2'd1;
    look(); check("sub Z0", {31'b0, Z}, 32'd0);
    go(); eR1 = 7; eR2 = 7;
    look(); check("sub mAns", mAns, 32'd2); check("sub Z1", {31'b0, Z}, 32'd1);

    // shifter
    go(); idle(); eR2 = 32'h8000_0000; eSa = 5'd4; esRight = 1; esArith = 1; eAnsSel = 2'd1;
    look();
    go(); esArith = 0;
    look(); check("sra", mAns, 32'hF800_0000);
    go(); esRight = 0; eR2 = 32'd1; eSa = 5'd31;
    look(); check("srl", mAns, 32'h0800_0000);
    go(); idle();
    look(); check("sll", mAns, 32'h8000_0000);

    // back-to-back forwarding
    go(); idle(); eR1 = 10; eI = 1;
    look();
    go(); eFwdA = 2'd1; eFwdB = 2'd2; wD = 32'h55; eI = 1;
    look(); check("fwd c1", mAns, 32'd11);
    go(); idle();
    look(); check("fwd c2", mAns, 32'd12); check("fwd mB", mB, 32'h55);

    // flush bubble, then hold with En=0 (also with Flush=1)
    go(); idle(); eWreg = 1; eReg2reg = 1; eWmem = 1; eRd = 5'd9; Flush = 1; eR1 = 3; eI = 4;
    look();
    go(); En = 0; Flush = 0; eWreg = 1; eRd = 5'd20; eR1 = 100;
    look();
    check("flush mWreg", {31'b0, mWreg}, 32'd0); check("flush mRd", {27'b0, mRd}, 32'd0);
    check("flush mAns", mAns, 32'd7); check("flush mWmem", {31'b0, mWmem}, 32'd0);
    go(); Flush = 1; eR1 = 50;
    look();
    check("hold mWreg", {31'b0, mWreg}, 32'd0); check("hold mRd", {27'b0, mRd}, 32'd0);
    check("hold mAns", mAns, 32'd7);

    // link and set-less-than
    go(); idle(); eAnsSel = 2'd2; ePc = 32'h104;
    look();
    go(); idle(); eAnsSel = 2'd3; eR1 = 32'hFFFF_FFFF; eR2 = 1; eI = 1; eAluqb = 1;
    look(); check("link", mAns, 32'h104);
    go(); idle();
    look(); check("slt", mAns, 32'd1);

    // reset mid-stream overrides En
    go(); rand_in(); Rst = 1; En = 1; Flush = 0;
    look(); check("midrst mAns", mAns, 32'h0); check("midrst mRd", {27'b0, mRd}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      go();
      rand_in();
      Rst   = ($urandom_range(0, 31) == 0);
      En    = ($urandom_range(0, 9) != 0);
      Flush = ($urandom_range(0, 6) == 0);
    end
    go(); idle();
    look();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-002 Clk  in  1  pipeline clock, all state updates on rising edge.
REQ-003 Rst  in  1  synchronous active-high reset.
REQ-004 En  in  1  stage enable; 0 holds all output registers.
REQ-005 Flush  in  1  kills the instruction entering EX/MEM (bubble insert).
REQ-006 eWreg, eReg2reg, eWmem  in  1 each  control bits from ID/EX.
REQ-007 eOp  in  6  opcode; eAluc  in  2  ALU op; eAluqb  in  1  B-operand select.
REQ-008 ePc, eR1, eR2, eI  in  32 each  PC+4, register operands, extended immediate.
REQ-009 eRd  in  5  destination register; eFwdA, eFwdB  in  2 each  forward selects.
REQ-010 eSa  in  5; esArith, esRight  in  1 each; eAnsSel  in  2  result select.
REQ-011 wD  in  32  write-back data for forwarding.
REQ-012 Z  out  1  combinational zero flag of the ALU result (branch resolution).
REQ-013 mWreg, mReg2reg, mWmem  out  1 each; mOp  out  6; mRd  out  5  registered.
REQ-014 mAns  out  32  registered result; mB  out  32  registered forwarded B (store data).

Function
REQ-015 Operand A SHALL be: eFwdA 00 -> eR1, 01 -> mAns, 10 -> wD, 11 -> eR1.
REQ-016 Forwarded B SHALL use eFwdB with the same encoding on eR2.
REQ-017 ALU B SHALL be forwarded B when eAluqb=1, eI when eAluqb=0.
REQ-018 ALU SHALL compute eAluc 00 A+B, 01 A-B, 10 A&B, 11 A|B, 32-bit, carry/overflow discarded.
REQ-019 Shifter input SHALL be forwarded B, amount eSa; esRight=0 logical left, esRight=1 esArith=0 logical right, esRight=1 esArith=1 arithmetic right; eSa=0 passes unchanged.
REQ-020 Result SHALL be eAnsSel 00 ALU, 01 shifter, 10 ePc (link), 11 {31'b0, signed A<B}.
REQ-021 Z SHALL be 1 iff ALU result == 0, independent of En/Flush.
REQ-022 Latency SHALL be one cycle: values present before edge N appear on m* after edge N.
REQ-023 When En=1, Flush=0: all m* outputs load the computed/passed values.
REQ-024 When En=0: all m* outputs hold, including when Flush=1.
REQ-025 When En=1, Flush=1: mWreg, mWmem, mReg2reg load 0, mRd loads 0, data outputs load computed values.
REQ-026 Forwarding from mAns SHALL use the pre-edge register value (no combinational loop through the new result).
REQ-027 Back-to-back dependent instructions with eFwdA=01 SHALL produce correct results every cycle with no stall.

Reset
REQ-028 Rst=1 at an edge SHALL clear every m* output to 0, overriding En and Flush.
REQ-029 Reset asserted mid-stream SHALL discard the in-flight instruction; first valid output is one cycle after Rst deasserts.
REQ-030 Z has no reset value (combinational).

Structure
REQ-031 AnsSel, Aluc and Fwd encodings SHALL be constants in the shared CPU package used by the control unit and ID/EX register.
REQ-032 Output registers SHALL be built from the codebase's enabled D flip-flop primitives, widths 1/5/6/32, extended with synchronous clear.
REQ-033 Shifter SHALL be one sub-module, shifter32, purely combinational.

Verification
REQ-034 Rst=1 one cycle with random inputs -> all m* = 0 after edge.
REQ-035 eR1=5, eR2=3, eAluqb=1, eAluc=01, eAnsSel=00 -> mAns=2, Z=0; eR1=eR2=7 -> Z=1.
REQ-036 eR2=0x80000000, eSa=4, esRight=1: esArith=1 -> mAns=0xF8000000; esArith=0 -> 0x08000000; esRight=0, eR2=1, eSa=31 -> 0x80000000.
REQ-037 Cycle1 eR1=10, eI=1, eAluqb=0, add -> mAns=11; cycle2 eFwdA=01, eI=1 -> mAns=12; eFwdB=10, wD=0x55 -> mB=0x55.
REQ-038 eWreg=1, eRd=9, En=1, Flush=1 -> mWreg=0, mRd=0; then En=0 with new inputs -> outputs unchanged.
REQ-039 eAnsSel=10, ePc=0x104 -> mAns=0x104; eAnsSel=11, A=-1, B=1 -> mAns=1.
